// File: rtl/bus_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Holds the reset polarity, FSM state encoding and default timeout.
package project_types;

   typedef logic reset_status_t;

   localparam reset_status_t RST_ENABLE = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      BUS_IF,
      BUS_MEM
   } arb_state_t;

   localparam int ARB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/bus_arbiter_timeout.sv
// Wait-state counter for the arbiter's bus timeout.
// Holds at LIMIT-1 once expired until cleared.
module arb_timeout_counter #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Serialises instruction fetch and data access onto one req/ack bus.
// Define ARB_TIMEOUT_EN to abort accesses that never see bus_ack.
module bus_arbiter
   import project_types::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  reset_status_t       rst,
   input  logic                if_en,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_data,
   output logic                if_stall_req,
   input  logic                mem_en,
   input  logic                mem_we,
   input  logic [DATA_W/8-1:0] mem_sel,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_stall_req,
   output logic                bus_req,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_sel,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_ack,
   output logic                bus_err
);

   localparam int SEL_W = DATA_W / 8;

   arb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] if_data_q, if_data_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_srv_q, if_srv_d;
   logic              mem_srv_q, mem_srv_d;
   logic              err_q, err_d;
   logic              pend_if, pend_mem, busy, abort;

   assign pend_if  = if_en & ~if_srv_q;
   assign pend_mem = mem_en & ~mem_srv_q;
   assign busy     = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
   logic expired;

   arb_timeout_counter #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst == RST_ENABLE),
      .clear_i  (~busy),
      .inc_i    (busy & ~bus_ack),
      .expired_o(expired)
   );

   assign abort = busy & ~bus_ack & expired;
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign abort          = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      sel_d       = sel_q;
      we_d        = we_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if_srv_d    = 1'b0;
      mem_srv_d   = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Data side holds the older instruction, so it wins.
            if (pend_mem) begin
               state_d = BUS_MEM;
               addr_d  = mem_addr;
               we_d    = mem_we;
               sel_d   = mem_sel;
               wdata_d = mem_wdata;
            end else if (pend_if) begin
               state_d = BUS_IF;
               addr_d  = if_addr;
               we_d    = 1'b0;
               sel_d   = '1;
            end
         end
         BUS_IF: begin
            if (bus_ack) begin
               if_data_d = bus_rdata;
               if_srv_d  = 1'b1;
               state_d   = IDLE;
            end else if (abort) begin
               if_data_d = '0;
               if_srv_d  = 1'b1;
               err_d     = 1'b1;
               state_d   = IDLE;
            end
         end
         BUS_MEM: begin
            if (bus_ack) begin
               if (!we_q) begin
                  mem_rdata_d = bus_rdata;
               end
               mem_srv_d = 1'b1;
               state_d   = IDLE;
            end else if (abort) begin
               mem_rdata_d = '0;
               mem_srv_d   = 1'b1;
               err_d       = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         if_srv_q    <= 1'b0;
         mem_srv_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         if_srv_q    <= if_srv_d;
         mem_srv_q   <= mem_srv_d;
         err_q       <= err_d;
      end
   end

   assign if_stall_req  = pend_if;
   assign mem_stall_req = pend_mem;
   assign bus_req       = busy;
   assign bus_we        = busy & we_q;
   assign bus_sel       = sel_q;
   assign bus_addr      = addr_q;
   assign bus_wdata     = wdata_q;
   assign if_data       = if_data_q;
   assign mem_rdata     = mem_rdata_q;
   assign bus_err       = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Random and directed checks of bus_arbiter against a transaction model.
// Follows ARB_TIMEOUT_EN; the DUT is built with a 4-cycle timeout.
module tb_bus_arbiter;

   localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_en, mem_en, mem_we, bus_ack;
   logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
   logic [3:0]  mem_sel;
   logic [31:0] if_data, mem_rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_sel;
   logic        if_stall_req, mem_stall_req;
   logic        bus_req, bus_we, bus_err;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bus_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_en        (if_en),
      .if_addr      (if_addr),
      .if_data      (if_data),
      .if_stall_req (if_stall_req),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_sel      (mem_sel),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_stall_req(mem_stall_req),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_sel      (bus_sel),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_rdata    (bus_rdata),
      .bus_ack      (bus_ack),
      .bus_err      (bus_err)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   // Model: one outstanding transaction record plus served/data state.
   bit          m_valid = 1'b0;
   int          m_cur;
   int          m_age;
   logic [31:0] m_addr, m_wdata, m_if_data, m_mem_rdata;
   logic [3:0]  m_sel;
   bit          m_we, m_if_srv, m_mem_srv, m_err;

   task automatic model_step();
      bit nif, nmem, nerr;
      if (rst) begin
         m_cur = 0; m_age = 0; m_addr = 0; m_wdata = 0;
         m_sel = 0; m_we = 0; m_if_data = 0; m_mem_rdata = 0;
         m_if_srv = 0; m_mem_srv = 0; m_err = 0;
         m_valid = 1'b1;
         return;
      end
      nif = 0; nmem = 0; nerr = 0;
      if (m_cur == 0) begin
         if (mem_en && !m_mem_srv) begin
            m_cur = 2; m_age = 0; m_addr = mem_addr;
            m_we = mem_we; m_sel = mem_sel; m_wdata = mem_wdata;
         end else if (if_en && !m_if_srv) begin
            m_cur = 1; m_age = 0; m_addr = if_addr;
            m_we = 0; m_sel = 4'hF;
         end
      end else if (bus_ack) begin
         if (m_cur == 1) begin
            m_if_data = bus_rdata; nif = 1;
         end else begin
            if (!m_we) m_mem_rdata = bus_rdata;
            nmem = 1;
         end
         m_cur = 0;
      end else if (TMO_ON && m_age == TMO - 1) begin
         if (m_cur == 1) begin
            m_if_data = 0; nif = 1;
         end else begin
            m_mem_rdata = 0; nmem = 1;
         end
         nerr = 1; m_cur = 0;
      end else begin
         m_age++;
      end
      m_if_srv = nif; m_mem_srv = nmem; m_err = nerr;
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("if_stall", {31'd0, if_stall_req}, {31'd0, if_en & ~m_if_srv});
         chk("mem_stall", {31'd0, mem_stall_req},
             {31'd0, mem_en & ~m_mem_srv});
         chk("bus_req", {31'd0, bus_req}, {31'd0, m_cur != 0});
         chk("bus_err", {31'd0, bus_err}, {31'd0, m_err});
         chk("if_data", if_data, m_if_data);
         chk("mem_rdata", mem_rdata, m_mem_rdata);
         if (m_cur != 0) begin
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_we", {31'd0, bus_we}, {31'd0, m_we});
            chk("bus_sel", {28'd0, bus_sel}, {28'd0, m_sel});
            if (m_cur == 2 && m_we) chk("bus_wdata", bus_wdata, m_wdata);
         end
      end
      model_step();
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ne();
      @(negedge clk);
   endtask

   int wcnt, wtgt;

   initial begin
      rst = 1; if_en = 0; if_addr = 0; mem_en = 0; mem_we = 0;
      mem_sel = 0; mem_addr = 0; mem_wdata = 0;
      bus_ack = 0; bus_rdata = 0;
      repeat (3) cyc();
      ne();
      chk("rst bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst bus_addr", bus_addr, 32'd0);
      chk("rst if_data", if_data, 32'd0);
      chk("rst mem_rdata", mem_rdata, 32'd0);
      chk("rst bus_err", {31'd0, bus_err}, 32'd0);
      cyc(); rst = 0;

      // fetch only, zero-wait
      cyc(); if_en = 1; if_addr = 32'h0000_0100;
      ne(); chk("t1 c0 stall", {31'd0, if_stall_req}, 32'd1);
      chk("t1 c0 req", {31'd0, bus_req}, 32'd0);
      cyc(); bus_ack = 1; bus_rdata = 32'h3C01_1234;
      ne(); chk("t1 c1 req", {31'd0, bus_req}, 32'd1);
      chk("t1 c1 addr", bus_addr, 32'h0000_0100);
      cyc(); bus_ack = 0;
      ne(); chk("t1 c2 data", if_data, 32'h3C01_1234);
      chk("t1 c2 stall", {31'd0, if_stall_req}, 32'd0);
      cyc(); if_en = 0;

      // simultaneous fetch and data read
      cyc(); if_en = 1; if_addr = 32'h0000_0200;
      mem_en = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h8000_0010;
      ne(); chk("t2 c0 ifst", {31'd0, if_stall_req}, 32'd1);
      chk("t2 c0 memst", {31'd0, mem_stall_req}, 32'd1);
      cyc(); bus_ack = 1; bus_rdata = 32'h1111_1111;
      ne(); chk("t2 c1 addr", bus_addr, 32'h8000_0010);
      chk("t2 c1 ifst", {31'd0, if_stall_req}, 32'd1);
      cyc(); bus_ack = 0;
      ne(); chk("t2 c2 memst", {31'd0, mem_stall_req}, 32'd0);
      chk("t2 c2 rdata", mem_rdata, 32'h1111_1111);
      chk("t2 c2 req", {31'd0, bus_req}, 32'd0);
      chk("t2 c2 ifst", {31'd0, if_stall_req}, 32'd1);
      cyc(); mem_en = 0; bus_ack = 1; bus_rdata = 32'h2222_2222;
      ne(); chk("t2 c3 req", {31'd0, bus_req}, 32'd1);
      chk("t2 c3 addr", bus_addr, 32'h0000_0200);
      cyc(); bus_ack = 0;
      ne(); chk("t2 c4 data", if_data, 32'h2222_2222);
      chk("t2 c4 ifst", {31'd0, if_stall_req}, 32'd0);
      cyc(); if_en = 0;

      // write with 3 wait states
      cyc(); mem_en = 1; mem_we = 1; mem_sel = 4'b0011;
      mem_addr = 32'h0000_0040; mem_wdata = 32'hDEAD_BEEF;
      for (int k = 0; k < 4; k++) begin
         cyc(); bus_ack = (k == 3); bus_rdata = 32'h9999_9999;
         ne(); chk("t3 req", {31'd0, bus_req}, 32'd1);
         chk("t3 we", {31'd0, bus_we}, 32'd1);
         chk("t3 sel", {28'd0, bus_sel}, 32'h3);
         chk("t3 wdata", bus_wdata, 32'hDEAD_BEEF);
         chk("t3 addr", bus_addr, 32'h0000_0040);
      end
      cyc(); bus_ack = 0;
      ne(); chk("t3 memst", {31'd0, mem_stall_req}, 32'd0);
      chk("t3 rdata", mem_rdata, 32'h1111_1111);
      cyc(); mem_en = 0; mem_we = 0;

      // reset during a data access, late ack
      cyc(); mem_en = 1; mem_addr = 32'h0000_0044; mem_sel = 4'hF;
      cyc(); rst = 1;
      ne(); chk("t4 c1 req", {31'd0, bus_req}, 32'd1);
      cyc(); rst = 0; bus_ack = 1; bus_rdata = 32'h5555_5555;
      ne(); chk("t4 c2 req", {31'd0, bus_req}, 32'd0);
      chk("t4 c2 memst", {31'd0, mem_stall_req}, 32'd1);
      chk("t4 c2 rdata", mem_rdata, 32'd0);
      cyc(); bus_rdata = 32'h6666_6666;
      ne(); chk("t4 c3 req", {31'd0, bus_req}, 32'd1);
      cyc(); bus_ack = 0;
      ne(); chk("t4 c4 rdata", mem_rdata, 32'h6666_6666);
      cyc(); mem_en = 0;

      // ack never arrives / arrives late
      cyc(); if_en = 1; if_addr = 32'h0000_0300;
`ifdef ARB_TIMEOUT_EN
      for (int k = 0; k < TMO; k++) begin
         cyc();
         ne(); chk("t5 req", {31'd0, bus_req}, 32'd1);
         chk("t5 err", {31'd0, bus_err}, 32'd0);
      end
      cyc();
      ne(); chk("t5 err pulse", {31'd0, bus_err}, 32'd1);
      chk("t5 data", if_data, 32'd0);
      chk("t5 ifst", {31'd0, if_stall_req}, 32'd0);
      cyc(); if_en = 0;
      ne(); chk("t5 err drop", {31'd0, bus_err}, 32'd0);
`else
      for (int k = 0; k < 40; k++) begin
         cyc();
         ne(); chk("t6 ifst", {31'd0, if_stall_req}, 32'd1);
         chk("t6 err", {31'd0, bus_err}, 32'd0);
      end
      cyc(); bus_ack = 1; bus_rdata = 32'h7777_7777;
      cyc(); bus_ack = 0;
      ne(); chk("t6 data", if_data, 32'h7777_7777);
      chk("t6 ifst", {31'd0, if_stall_req}, 32'd0);
      cyc(); if_en = 0;
`endif

      // random traffic with a reactive bus slave
      wcnt = 0; wtgt = 1;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) == 0) begin
            if_en   = 1'($urandom_range(0, 1));
            if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if ($urandom_range(0, 3) == 0) begin
            mem_en    = 1'($urandom_range(0, 1));
            mem_we    = 1'($urandom_range(0, 1));
            mem_sel   = 4'($urandom);
            mem_addr  = $urandom;
            mem_wdata = $urandom;
         end
         bus_rdata = $urandom;
         if (bus_req) begin
            if (wcnt >= wtgt) begin
               bus_ack = 1;
               wcnt = 0;
               wtgt = $urandom_range(0, TMO_ON ? 5 : 3);
            end else begin
               bus_ack = 0;
               wcnt++;
            end
         end else begin
            bus_ack = ($urandom_range(0, 7) == 0);
            wcnt = 0;
         end
      end
      cyc();
      ne();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
